// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: per-core picorv32 native buses plus the shared memory port
interface mem_rr_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ID_BITS = 2
);
    logic [N_CORES-1:0]    s_valid;
    logic [N_CORES-1:0]    s_ready;
    logic [32*N_CORES-1:0] s_addr;
    logic [32*N_CORES-1:0] s_wdata;
    logic [4*N_CORES-1:0]  s_wstrb;
    logic [32*N_CORES-1:0] s_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wstrb;
    logic [31:0]           m_rdata;
    logic [ID_BITS-1:0]    m_core_id;
    logic                  timeout;
    modport master (
        output s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
        input  s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb, m_core_id, timeout
    );
    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
        output s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb, m_core_id, timeout
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin share of one memory port among N_CORES cores; ARB_TIMEOUT_EN adds forced completion
module mem_rr_arbiter #(
    parameter int N_CORES = 4,
    parameter int ID_BITS = 2
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
`endif
) (
    input logic            clk,
    input logic            reset,
    mem_rr_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ID_BITS-1:0]    ptr_q, ptr_d;
    logic [ID_BITS-1:0]    core_q, core_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  mvalid_q, mvalid_d;
    logic [N_CORES-1:0]    sready_q, sready_d;
    logic [32*N_CORES-1:0] srdata_q, srdata_d;
    logic                  found;
    int                    g, idx;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;
    assign bus.timeout = tout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.m_valid   = mvalid_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_core_id = core_q;
    assign bus.s_ready   = sready_q;
    assign bus.s_rdata   = srdata_q;

    // pick the first requester at or after ptr, then sequence grant, ack and ready pulse
    always_comb begin
        found    = 1'b0;
        g        = 0;
        idx      = 0;
        state_d  = state_q;
        ptr_d    = ptr_q;
        core_d   = core_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        mvalid_d = mvalid_q;
        sready_d = '0;
        srdata_d = srdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tout_d   = 1'b0;
`endif
        for (int k = 0; k < N_CORES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (!found && bus.s_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        case (state_q)
            IDLE: if (found) begin
                core_d   = ID_BITS'(g);
                addr_d   = bus.s_addr[32*g +: 32];
                wdata_d  = bus.s_wdata[32*g +: 32];
                wstrb_d  = bus.s_wstrb[4*g +: 4];
                mvalid_d = 1'b1;
                ptr_d    = (g == N_CORES - 1) ? '0 : ID_BITS'(g + 1);
                state_d  = BUSY;
`ifdef ARB_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            BUSY: if (bus.m_ready) begin
                srdata_d[32*core_q +: 32] = bus.m_rdata;
                sready_d[core_q]          = 1'b1;
                mvalid_d                  = 1'b0;
                state_d                   = RESP;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                srdata_d[32*core_q +: 32] = ERR_WORD;
                sready_d[core_q]          = 1'b1;
                mvalid_d                  = 1'b0;
                tout_d                    = 1'b1;
                state_d                   = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset drops any in-flight access immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            core_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            mvalid_q <= 1'b0;
            sready_q <= '0;
            srdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            tout_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            core_q   <= core_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            mvalid_q <= mvalid_d;
            sready_q <= sready_d;
            srdata_q <= srdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tout_q   <= tout_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed checks of grant order, hold, ready pulse, reset abort and timeout
module tb_mem_rr_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;

    mem_rr_arbiter_if #(.N_CORES(4), .ID_BITS(2)) bus ();

`ifdef ARB_TIMEOUT_EN
    mem_rr_arbiter #(.N_CORES(4), .ID_BITS(2), .TIMEOUT_CYCLES(8), .ERR_WORD(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`else
    mem_rr_arbiter #(.N_CORES(4), .ID_BITS(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_mvalid"}, 128'(bus.m_valid), 128'(0));
        chk({tag, "_sready"}, 128'(bus.s_ready), 128'(0));
        chk({tag, "_srdata"}, 128'(bus.s_rdata), 128'(0));
        chk({tag, "_maddr"}, 128'({bus.m_addr, bus.m_wdata, bus.m_wstrb}), 128'(0));
        chk({tag, "_coreid"}, 128'(bus.m_core_id), 128'(0));
        chk({tag, "_timeout"}, 128'(bus.timeout), 128'(0));
    endtask

    initial begin
        bus.s_valid = '0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_wstrb = '0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        tick();
        tick();
        all_zero("reset");
        reset = 1'b0;
        tick();
        bus.m_ready = 1'b1;
        tick();
        chk("idle_mready_ignored", 128'(bus.s_ready), 128'(0));
        bus.m_ready = 1'b0;
        // single read from core 2, ack two cycles after grant
        bus.s_valid = 4'b0100;
        bus.s_addr[64 +: 32] = 32'h10;
        tick();
        chk("t1_grant_valid", 128'(bus.m_valid), 128'(1));
        chk("t1_core_id", 128'(bus.m_core_id), 128'(2));
        chk("t1_addr", 128'(bus.m_addr), 128'(32'h10));
        tick();
        chk("t1_wait_valid", 128'(bus.m_valid), 128'(1));
        chk("t1_wait_sready", 128'(bus.s_ready), 128'(0));
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h12345678;
        tick();
        bus.m_ready = 1'b0;
        bus.s_valid = '0;
        chk("t1_sready", 128'(bus.s_ready), 128'(4'b0100));
        chk("t1_srdata", 128'(bus.s_rdata), {32'h0, 32'h12345678, 64'h0});
        chk("t1_mvalid_off", 128'(bus.m_valid), 128'(0));
        tick();
        chk("t1_sready_pulse", 128'(bus.s_ready), 128'(0));
        // core 1 granted, then reset mid BUSY
        bus.s_valid = 4'b0010;
        bus.s_addr[32 +: 32] = 32'h20;
        tick();
        chk("t4_core_id", 128'(bus.m_core_id), 128'(1));
        chk("t4_valid", 128'(bus.m_valid), 128'(1));
        reset = 1'b1;
        bus.s_valid = '0;
        #1;
        all_zero("t4_async");
        tick();
        reset = 1'b0;
        tick();
        chk("t4_no_ready_a", 128'({bus.s_ready, bus.m_valid}), 128'(0));
        tick();
        chk("t4_no_ready_b", 128'({bus.s_ready, bus.m_valid}), 128'(0));
        // all four requesting, always acked: order 0,1,2,3,0 every 3 cycles
        bus.s_valid = 4'hF;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t2_grant%0d_valid", i), 128'(bus.m_valid), 128'(1));
            chk($sformatf("t2_grant%0d_id", i), 128'(bus.m_core_id), 128'(i % 4));
            bus.m_rdata = 32'h100 + 32'(i);
            tick();
            chk($sformatf("t2_grant%0d_ready", i), 128'(bus.s_ready), 128'(4'b1 << (i % 4)));
            tick();
            chk($sformatf("t2_grant%0d_pulse", i), 128'(bus.s_ready), 128'(0));
        end
        chk("t2_srdata", 128'(bus.s_rdata), {32'h103, 32'h102, 32'h101, 32'h104});
        bus.s_valid = '0;
        bus.m_ready = 1'b0;
        // core 3 write held stable while core 0 queues behind it
        bus.s_valid = 4'b1000;
        bus.s_addr[96 +: 32] = 32'h1000_0004;
        bus.s_wdata[96 +: 32] = 32'hA5;
        bus.s_wstrb[12 +: 4] = 4'hF;
        tick();
        chk("t3_grant", 128'({bus.m_valid, bus.m_core_id, bus.m_addr, bus.m_wdata, bus.m_wstrb}),
            128'({1'b1, 2'd3, 32'h1000_0004, 32'hA5, 4'hF}));
        bus.s_valid = 4'b1001;
        bus.s_addr[96 +: 32] = 32'hFFFF_FFFF;
        bus.s_wdata[96 +: 32] = 32'h0;
        tick();
        chk("t3_hold_a", 128'({bus.m_valid, bus.m_core_id, bus.m_addr, bus.m_wdata, bus.m_wstrb}),
            128'({1'b1, 2'd3, 32'h1000_0004, 32'hA5, 4'hF}));
        tick();
        chk("t3_hold_b", 128'({bus.m_valid, bus.m_core_id, bus.m_addr, bus.m_wdata, bus.m_wstrb}),
            128'({1'b1, 2'd3, 32'h1000_0004, 32'hA5, 4'hF}));
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h103;
        tick();
        bus.m_ready = 1'b0;
        bus.s_valid = 4'b0001;
        chk("t3_ready", 128'(bus.s_ready), 128'(4'b1000));
        chk("t3_srdata", 128'(bus.s_rdata), {32'h103, 32'h102, 32'h101, 32'h104});
        tick();
        tick();
        chk("t3_next_core0", 128'({bus.m_valid, bus.m_core_id}), 128'({1'b1, 2'd0}));
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h5555_AAAA;
        tick();
        bus.m_ready = 1'b0;
        bus.s_valid = '0;
        chk("t3_core0_ready", 128'(bus.s_ready), 128'(4'b0001));
        chk("t3_core0_srdata", 128'(bus.s_rdata), {32'h103, 32'h102, 32'h101, 32'h5555_AAAA});
        tick();
`ifdef ARB_TIMEOUT_EN
        // no ack: forced completion with the error word
        bus.s_valid = 4'b0010;
        tick();
        chk("t5_core_id", 128'(bus.m_core_id), 128'(1));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t5_wait%0d", i), 128'({bus.s_ready, bus.timeout, bus.m_valid}), 128'(1));
        end
        tick();
        bus.s_valid = '0;
        chk("t5_timeout", 128'(bus.timeout), 128'(1));
        chk("t5_ready", 128'(bus.s_ready), 128'(4'b0010));
        chk("t5_srdata", 128'(bus.s_rdata[32 +: 32]), 128'(32'hDEADBEEF));
        tick();
        chk("t5_timeout_pulse", 128'(bus.timeout), 128'(0));
        // ack arriving at the timeout edge wins
        bus.s_valid = 4'b0100;
        tick();
        for (int i = 0; i < 8; i++) tick();
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h0BAD_F00D;
        tick();
        bus.m_ready = 1'b0;
        bus.s_valid = '0;
        chk("t6_timeout", 128'(bus.timeout), 128'(0));
        chk("t6_ready", 128'(bus.s_ready), 128'(4'b0100));
        chk("t6_srdata", 128'(bus.s_rdata[64 +: 32]), 128'(32'h0BAD_F00D));
        tick();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
